unified_mem_arbiter: RTL and testbench

//  Shares the single-port unified instruction/data memory between the fetch stage (I) and the

---
 rtl/unified_mem_arbiter_if.sv | 27 ++
 rtl/unified_mem_arbiter.sv | 87 ++++++++
 tb/tb_unified_mem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: core request/ack channels plus the unified memory port.
// master = core and memory side, slave = arbiter.
interface unified_mem_arbiter_if #(parameter int WORD_SIZE = 32);
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic                 i_ack;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_ack;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 mem_write_en;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_write_data;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 busy;
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_write_en, mem_addr, mem_write_data, busy
    );
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data,
        output i_ack, i_rdata, d_ack, d_rdata, mem_write_en, mem_addr, mem_write_data, busy
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one memory port between fetch (I) and load/store (D), one access per 3 cycles.
// Define ARB_STARVE_GUARD_EN to force an I grant after STARVE_LIMIT consecutive D grants with I pending.
module unified_mem_arbiter #(
    parameter int WORD_SIZE    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic                   clk,
    input logic                   rst,
    unified_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t               state_q, state_d;
    logic                 dsel_q, dsel_d;
    logic                 we_q, we_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 grant_i;
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end
`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    assign grant_i = bus.i_req && (!bus.d_req || starve_cnt_q == SW'(STARVE_LIMIT));
    // Only IDLE arbitrations with a request move the counter
    always_comb
        starve_cnt_d = (state_q != IDLE || !(bus.i_req || bus.d_req)) ? starve_cnt_q :
                       (!grant_i && bus.i_req) ? starve_cnt_q + 1'b1 : '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
`else
    assign grant_i = bus.i_req && !bus.d_req;
`endif
    always_comb begin
        state_d   = state_q;
        dsel_d    = dsel_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (state_q == IDLE && (bus.i_req || bus.d_req)) begin
            state_d = ACCESS;
            dsel_d  = !grant_i;
            we_d    = !grant_i && bus.d_we;
            addr_d  = grant_i ? bus.i_addr : bus.d_addr;
            wdata_d = grant_i ? wdata_q : bus.d_wdata;
        end else if (state_q == ACCESS) begin
            state_d   = RESP;
            i_rdata_d = (!we_q && !dsel_q) ? bus.mem_data : i_rdata_q;
            d_rdata_d = (!we_q && dsel_q) ? bus.mem_data : d_rdata_q;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dsel_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            dsel_q    <= dsel_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end
    // Decoded from state so an async reset drops the write strobe immediately
    assign bus.mem_write_en   = state_q == ACCESS && dsel_q && we_q;
    assign bus.busy           = state_q != IDLE;
    assign bus.i_ack          = state_q == RESP && !dsel_q;
    assign bus.d_ack          = state_q == RESP && dsel_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.i_rdata        = i_rdata_q;
    assign bus.d_rdata        = d_rdata_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: table-driven transactions plus hand sequences for reset, contention and starvation.
module tb_unified_mem_arbiter;
    logic clk, rst;
    int   n_cmp, n_bad;
    logic [31:0] mem [0:63];
    unified_mem_arbiter_if #(.WORD_SIZE(32)) bus ();
    unified_mem_arbiter #(.WORD_SIZE(32), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.mem_data = mem[bus.mem_addr[7:2]];
    always @(posedge clk) if (bus.mem_write_en) mem[bus.mem_addr[7:2]] <= bus.mem_write_data;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: timeout act=running req=finished");
        $fatal(1);
    end
    typedef struct packed {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic        exp_i_ack;
        logic        exp_d_ack;
        logic [31:0] exp_i_rdata;
        logic [31:0] exp_d_rdata;
    } vec_t;
    vec_t vecs [8];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic run_vec(input vec_t v);
        bus.i_req = v.i_req; bus.i_addr = v.i_addr;
        bus.d_req = v.d_req; bus.d_we = v.d_we; bus.d_addr = v.d_addr; bus.d_wdata = v.d_wdata;
        @(posedge clk); #1;
        chk("access_busy", 32'(bus.busy), 32'd1);
        chk("access_addr", bus.mem_addr, v.exp_addr);
        chk("access_we", 32'(bus.mem_write_en), 32'(v.exp_we));
        if (v.exp_we) chk("access_wdata", bus.mem_write_data, v.d_wdata);
        @(posedge clk); #1;
        chk("resp_i_ack", 32'(bus.i_ack), 32'(v.exp_i_ack));
        chk("resp_d_ack", 32'(bus.d_ack), 32'(v.exp_d_ack));
        chk("resp_i_rdata", bus.i_rdata, v.exp_i_rdata);
        chk("resp_d_rdata", bus.d_rdata, v.exp_d_rdata);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        @(posedge clk); #1;
        chk("idle_outs", {28'd0, bus.busy, bus.i_ack, bus.d_ack, bus.mem_write_en}, 32'd0);
    endtask
    // Runs n cycles with the given requests held, recording ack cycles as bitmasks
    task automatic watch(input int n, input logic drop_on_ack, output logic [31:0] im, output logic [31:0] dm);
        im = '0; dm = '0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            im[c] = bus.i_ack;
            dm[c] = bus.d_ack;
            if (drop_on_ack && bus.i_ack) bus.i_req = 1'b0;
            if (drop_on_ack && bus.d_ack) bus.d_req = 1'b0;
        end
    endtask
    initial begin
        logic [31:0] im, dm, exp_im, exp_dm;
        n_cmp = 0; n_bad = 0;
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        mem[0] = 32'h01500093; mem[1] = 32'h00000013; mem[2] = 32'hDEADBEEF; mem[6] = 32'h0BADF00D;
        vecs[0] = '{1'b1, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         32'h0,  1'b0, 1'b1, 1'b0, 32'h01500093, 32'h0};
        vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h18, 32'h15,        32'h18, 1'b1, 1'b0, 1'b1, 32'h01500093, 32'h0};
        vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h18, 32'h0,         32'h18, 1'b0, 1'b0, 1'b1, 32'h01500093, 32'h15};
        vecs[3] = '{1'b1, 32'h4,  1'b1, 1'b0, 32'h8,  32'h0,         32'h8,  1'b0, 1'b0, 1'b1, 32'h01500093, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 32'h4,  1'b0, 1'b0, 32'h0,  32'h0,         32'h4,  1'b0, 1'b1, 1'b0, 32'h00000013, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 32'h9,  1'b0, 1'b0, 32'h0,  32'h0,         32'h9,  1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 32'h0,  1'b1, 1'b1, 32'h1C, 32'hA5A50001,  32'h1C, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[7] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h1C, 32'h0,         32'h1C, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'hA5A50001};
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {28'd0, bus.busy, bus.i_ack, bus.d_ack, bus.mem_write_en}, 32'd0);
        chk("reset_rdata", bus.i_rdata | bus.d_rdata | bus.mem_addr | bus.mem_write_data, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        // Reset asserted in the middle of a store's ACCESS cycle
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h18; bus.d_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        chk("mid_store_we", 32'(bus.mem_write_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_store_we_fall", 32'(bus.mem_write_en), 32'd0);
        chk("mid_store_outs", {28'd0, bus.busy, bus.i_ack, bus.d_ack, bus.mem_write_en}, 32'd0);
        chk("mid_store_regs", bus.i_rdata | bus.d_rdata | bus.mem_addr | bus.mem_write_data, 32'd0);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(posedge clk); #1;
        chk("mid_store_mem", mem[6], 32'h0BADF00D);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 8; n++) run_vec(vecs[n]);
        chk("store_mem_18", mem[6], 32'h15);
        // Contention: D first, then I three cycles later
        bus.i_req = 1'b1; bus.i_addr = 32'h0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4;
        watch(7, 1'b1, im, dm);
        chk("contend_d_ack", dm, 32'h1 << 2);
        chk("contend_i_ack", im, 32'h1 << 5);
        chk("contend_i_rdata", bus.i_rdata, 32'h01500093);
        chk("contend_d_rdata", bus.d_rdata, 32'h00000013);
        // Back-to-back fetch with i_req held across ack
        bus.i_req = 1'b1; bus.i_addr = 32'h8;
        watch(9, 1'b0, im, dm);
        bus.i_req = 1'b0;
        chk("b2b_i_ack", im, (32'h1 << 2) | (32'h1 << 5) | (32'h1 << 8));
        chk("b2b_d_ack", dm, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        // Starvation: both held
        bus.i_req = 1'b1; bus.i_addr = 32'h0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h18;
        watch(18, 1'b0, im, dm);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        exp_im = 32'h1 << 14;
        exp_dm = (32'h1 << 2) | (32'h1 << 5) | (32'h1 << 8) | (32'h1 << 11) | (32'h1 << 17);
`else
        exp_im = 32'h0;
        exp_dm = (32'h1 << 2) | (32'h1 << 5) | (32'h1 << 8) | (32'h1 << 11) | (32'h1 << 14) | (32'h1 << 17);
`endif
        chk("starve_i_ack", im, exp_im);
        chk("starve_d_ack", dm, exp_dm);
        chk("starve_d_rdata", bus.d_rdata, 32'h15);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
